// File: rtl/controle_pkg.sv
// controle_pkg -- shared definitions for the controle_seq sequencer.
//   * register-channel command codes (cmd_t)
//   * ALU operation codes (alu_t)
//   * sequencer FSM state encoding (state_t)
//   * fixed program geometry (number of programmed channels / steps)
package controle_pkg;

  typedef enum logic [2:0] {
    CMD_HOLD   = 3'b000,
    CMD_LOAD   = 3'b001,
    CMD_SHIFTR = 3'b010,
    CMD_SHIFTL = 3'b011,
    CMD_RESET  = 3'b100
  } cmd_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_MAIOR = 3'b010,
    ALU_MENOR = 3'b011,
    ALU_IGUAL = 3'b100,
    ALU_XOR   = 3'b101,
    ALU_AND   = 3'b110
  } alu_t;

  // Op code with no ALU meaning; it is latched as ADD.
  localparam logic [2:0] OP_INVALID = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Channels 0..2 (X, Y, Z) carry the program; the rest only ever hold.
  localparam int PROG_CHANNELS = 3;
  // Steps 0..4 carry the program; later steps only hold.
  localparam int PROG_STEPS    = 5;

endpackage

// File: rtl/controle_rom.sv
// controle_rom -- purely combinational program table.
// Maps the current step and the latched ALU op to per-channel register
// commands and the ALU operation. Gating by FSM state is done by the caller.
//   step  : current step index (4 bits)
//   op    : latched ALU operation (CW bits)
//   treg  : packed channel commands, channel i at [i*CW +: CW]
//   tula  : ALU operation for this step
module controle_rom
  import controle_pkg::*;
#(
  parameter int N_REG = 3,
  parameter int CW    = 3
) (
  input  logic [3:0]          step,
  input  logic [CW-1:0]       op,
  output logic [N_REG*CW-1:0] treg,
  output logic [CW-1:0]       tula
);

  cmd_t x_cmd;
  cmd_t y_cmd;
  cmd_t z_cmd;

  always_comb begin
    x_cmd = CMD_HOLD;
    y_cmd = CMD_HOLD;
    z_cmd = CMD_HOLD;
    case (step)
      4'd0: begin x_cmd = CMD_LOAD;  y_cmd = CMD_RESET;  z_cmd = CMD_RESET; end
      4'd1: begin x_cmd = CMD_LOAD;  y_cmd = CMD_LOAD;   z_cmd = CMD_HOLD;  end
      4'd2: begin x_cmd = CMD_RESET; y_cmd = CMD_LOAD;   z_cmd = CMD_RESET; end
      4'd3: begin x_cmd = CMD_RESET; y_cmd = CMD_SHIFTR; z_cmd = CMD_RESET; end
      4'd4: begin x_cmd = CMD_RESET; y_cmd = CMD_RESET;  z_cmd = CMD_LOAD;  end
      default: ;  // padding steps of longer programs hold everything
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REG; gi++) begin : g_chan
      if (gi == 0) begin : g_x
        assign treg[gi*CW +: CW] = CW'(x_cmd);
      end else if (gi == 1) begin : g_y
        assign treg[gi*CW +: CW] = CW'(y_cmd);
      end else if (gi == 2) begin : g_z
        assign treg[gi*CW +: CW] = CW'(z_cmd);
      end else begin : g_aux
        assign treg[gi*CW +: CW] = CW'(CMD_HOLD);
      end
    end
  endgenerate

  // The op is already sanitised when latched, so it passes straight through.
  assign tula = op;

endmodule

// File: rtl/controle_seq.sv
// controle_seq -- fixed-program datapath sequencer.
// On an accepted start in IDLE it runs STEPS cycles in RUN, driving register
// commands (Treg) and the ALU op (Tula) from a program table, then pulses
// done for one DONE cycle and returns to IDLE.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start, op     : run request and ALU op (sampled only in IDLE)
//   abort         : only with CONTROLE_SEQ_ABORT_EN defined; cancels a run
//   Treg          : N_REG packed channel commands (0=X, 1=Y, 2=Z, 3+ aux)
//   Tula          : ALU operation for the current step
//   step          : current step index (0 outside RUN)
//   busy, done    : RUN indicator and one-cycle completion pulse
// Optional feature macro: CONTROLE_SEQ_ABORT_EN.
module controle_seq
  import controle_pkg::*;
#(
  parameter int N_REG = 3,
  parameter int CW    = 3,
  parameter int STEPS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CW-1:0]       op,
`ifdef CONTROLE_SEQ_ABORT_EN
  input  logic                abort,
`endif
  output logic [N_REG*CW-1:0] Treg,
  output logic [CW-1:0]       Tula,
  output logic [3:0]          step,
  output logic                busy,
  output logic                done
);

  localparam logic [3:0] LAST_STEP = 4'(STEPS - 1);

  state_t        state_q, state_d;
  logic [3:0]    step_q,  step_d;
  logic [CW-1:0] op_q,    op_d;

  logic [N_REG*CW-1:0] rom_treg;
  logic [CW-1:0]       rom_tula;
  logic                abort_hit;

`ifdef CONTROLE_SEQ_ABORT_EN
  assign abort_hit = abort && (state_q == ST_RUN);
`else
  assign abort_hit = 1'b0;
`endif

  controle_rom #(
    .N_REG (N_REG),
    .CW    (CW)
  ) u_rom (
    .step (step_q),
    .op   (op_q),
    .treg (rom_treg),
    .tula (rom_tula)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= 4'd0;
      op_q    <= CW'(ALU_ADD);
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      op_q    <= op_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        step_d = 4'd0;
        if (start) begin
          state_d = ST_RUN;
          op_d    = (op == CW'(OP_INVALID)) ? CW'(ALU_ADD) : op;
        end
      end
      ST_RUN: begin
        if (abort_hit) begin
          state_d = ST_IDLE;
          step_d  = 4'd0;
        end else if (step_q == LAST_STEP) begin
          state_d = ST_DONE;
          step_d  = 4'd0;
        end else begin
          step_d  = step_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        step_d  = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        step_d  = 4'd0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
    step = step_q;
    Treg = '0;  // all channels HOLD
    Tula = CW'(ALU_ADD);
    if (state_q == ST_RUN) begin
      Tula = rom_tula;
      if (abort_hit) begin
        for (int i = 0; i < N_REG; i++) begin
          Treg[i*CW +: CW] = CW'(CMD_RESET);
        end
      end else begin
        Treg = rom_treg;
      end
    end
  end

endmodule

// File: tb/tb_controle_seq.sv
// tb_controle_seq -- directed self-checking bench for controle_seq.
// Instance A uses default parameters, instance B uses N_REG=5, STEPS=8.
module tb_controle_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic       rst_a, start_a;
  logic [2:0] op_a;
  logic [8:0] treg_a;
  logic [2:0] tula_a;
  logic [3:0] step_a;
  logic       busy_a, done_a;
  logic       abort_a;

  // Instance B signals
  logic        rst_b, start_b;
  logic [2:0]  op_b;
  logic [14:0] treg_b;
  logic [2:0]  tula_b;
  logic [3:0]  step_b;
  logic        busy_b, done_b;
  logic        abort_b;

  int checks   = 0;
  int failures = 0;

  // Hand-written program table (X, Y, Z) for steps 0..4
  logic [2:0] x_tab [5] = '{3'd1, 3'd1, 3'd4, 3'd4, 3'd4};
  logic [2:0] y_tab [5] = '{3'd4, 3'd1, 3'd1, 3'd2, 3'd4};
  logic [2:0] z_tab [5] = '{3'd4, 3'd0, 3'd4, 3'd4, 3'd1};

  controle_seq u_dut_a (
    .clk   (clk),
    .rst   (rst_a),
    .start (start_a),
    .op    (op_a),
`ifdef CONTROLE_SEQ_ABORT_EN
    .abort (abort_a),
`endif
    .Treg  (treg_a),
    .Tula  (tula_a),
    .step  (step_a),
    .busy  (busy_a),
    .done  (done_a)
  );

  controle_seq #(.N_REG(5), .CW(3), .STEPS(8)) u_dut_b (
    .clk   (clk),
    .rst   (rst_b),
    .start (start_b),
    .op    (op_b),
`ifdef CONTROLE_SEQ_ABORT_EN
    .abort (abort_b),
`endif
    .Treg  (treg_b),
    .Tula  (tula_b),
    .step  (step_b),
    .busy  (busy_b),
    .done  (done_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s got=%0h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_treg(input int s);
    logic [63:0] r;
    r = '0;
    if (s < 5) r = 64'({z_tab[s], y_tab[s], x_tab[s]});
    return r;
  endfunction

  task automatic check_step_a(input int s, input logic [2:0] tula_exp);
    check($sformatf("a_s%0d_step", s), 64'(step_a), 64'(s));
    check($sformatf("a_s%0d_busy", s), 64'(busy_a), 64'd1);
    check($sformatf("a_s%0d_done", s), 64'(done_a), 64'd0);
    check($sformatf("a_s%0d_tula", s), 64'(tula_a), 64'(tula_exp));
    check($sformatf("a_s%0d_treg", s), 64'(treg_a), exp_treg(s));
  endtask

  task automatic check_done_a(input string tag);
    check({tag, "_done"}, 64'(done_a), 64'd1);
    check({tag, "_busy"}, 64'(busy_a), 64'd0);
    check({tag, "_step"}, 64'(step_a), 64'd0);
    check({tag, "_treg"}, 64'(treg_a), 64'd0);
    check({tag, "_tula"}, 64'(tula_a), 64'd0);
  endtask

  initial begin
    rst_a = 1'b1; start_a = 1'b1; op_a = 3'b001; abort_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; op_b = 3'b000; abort_b = 1'b0;

    // Reset overrides start
    tick;
    tick;
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_step", 64'(step_a), 64'd0);
    check("rst_treg", 64'(treg_a), 64'd0);
    check("rst_tula", 64'(tula_a), 64'd0);
    check("rst_b_treg", 64'(treg_b), 64'd0);

    // Single run with op=SUB
    rst_a = 1'b0; rst_b = 1'b0;
    start_a = 1'b1; op_a = 3'b001;
    tick;
    start_a = 1'b0;
    for (int s = 0; s < 5; s++) begin
      check_step_a(s, 3'b001);
      tick;
    end
    check_done_a("run1");
    tick;
    check("run1_idle_done", 64'(done_a), 64'd0);
    check("run1_idle_busy", 64'(busy_a), 64'd0);

    // start held high: RUN x5, DONE, IDLE, repeat
    start_a = 1'b1; op_a = 3'b101;
    for (int c = 0; c < 14; c++) begin
      tick;
      check($sformatf("hold_c%0d_busy", c), 64'(busy_a), 64'((c % 7) < 5));
      check($sformatf("hold_c%0d_done", c), 64'(done_a), 64'((c % 7) == 5));
      check($sformatf("hold_c%0d_step", c), 64'(step_a), ((c % 7) < 5) ? 64'(c % 7) : 64'd0);
    end
    start_a = 1'b0;
    tick;
    check("hold_end_busy", 64'(busy_a), 64'd0);

    // op=111 latches as ADD; op changes during the run are ignored
    op_a = 3'b111; start_a = 1'b1;
    tick;
    start_a = 1'b0;
    for (int s = 0; s < 5; s++) begin
      check_step_a(s, 3'b000);
      op_a = 3'(s) ^ 3'b011;
      tick;
    end
    check_done_a("op7");
    tick;

    // Reset in the middle of a run: no done pulse
    op_a = 3'b011; start_a = 1'b1;
    tick;
    start_a = 1'b0;
    tick;
    tick;
    check("midrst_step", 64'(step_a), 64'd2);
    rst_a = 1'b1;
    tick;
    rst_a = 1'b0;
    check("midrst_busy", 64'(busy_a), 64'd0);
    check("midrst_step0", 64'(step_a), 64'd0);
    check("midrst_treg", 64'(treg_a), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("midrst_nodone%0d", i), 64'(done_a), 64'd0);
    end

`ifdef CONTROLE_SEQ_ABORT_EN
    // Abort at step 2: RESET on all channels that cycle, then IDLE
    op_a = 3'b001; start_a = 1'b1;
    tick;
    start_a = 1'b0;
    tick;
    tick;
    abort_a = 1'b1;
    #1;
    check("abort_treg", 64'(treg_a), 64'h124);
    check("abort_busy", 64'(busy_a), 64'd1);
    tick;
    abort_a = 1'b0;
    check("abort_idle_busy", 64'(busy_a), 64'd0);
    check("abort_idle_done", 64'(done_a), 64'd0);
    tick;
    check("abort_nodone", 64'(done_a), 64'd0);
    // Abort is ignored in IDLE: start is still accepted
    abort_a = 1'b1; start_a = 1'b1;
    tick;
    check("abort_idle_start_busy", 64'(busy_a), 64'd1);
    abort_a = 1'b0; start_a = 1'b0;
    #1;
    check("abort_idle_start_treg", 64'(treg_a), exp_treg(0));
    for (int i = 0; i < 5; i++) tick;
    check("abort_idle_start_done", 64'(done_a), 64'd1);
    tick;
`endif

    // Instance B: 5 channels, 8 steps
    op_b = 3'b100; start_b = 1'b1;
    tick;
    start_b = 1'b0;
    for (int s = 0; s < 8; s++) begin
      check($sformatf("b_s%0d_step", s), 64'(step_b), 64'(s));
      check($sformatf("b_s%0d_busy", s), 64'(busy_b), 64'd1);
      check($sformatf("b_s%0d_tula", s), 64'(tula_b), 64'd4);
      check($sformatf("b_s%0d_treg", s), 64'(treg_b), exp_treg(s));
      tick;
    end
    check("b_done", 64'(done_b), 64'd1);
    check("b_done_busy", 64'(busy_b), 64'd0);
    tick;
    check("b_idle_done", 64'(done_b), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controle_seq.md
CONTROLE_SEQ -- requirements
Module: controle_seq

Interface
REQ-001 Parameter N_REG, default 3: number of register-command channels; range 3..8.
REQ-002 Parameter CW, default 3: width of each command and of the ALU op field.
REQ-003 Parameter STEPS, default 5: program length in steps; range 5..16.
REQ-004 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port start, input, 1: request to run one program; sampled only in IDLE.
REQ-007 Port op, input, CW: ALU operation requested for this run; latched on accepted start.
REQ-008 Port Treg, output, N_REG*CW: register commands; channel 0=X, 1=Y, 2=Z, channels 3+ auxiliary.
REQ-009 Port Tula, output, CW: ALU operation for the current step.
REQ-010 Port step, output, 4: current step index.
REQ-011 Port busy, output, 1: high in RUN.
REQ-012 Port done, output, 1: one-cycle completion pulse.

Function
REQ-013 Register command codes SHALL be HOLD=000, LOAD=001, SHIFTR=010, SHIFTL=011, RESET=100.
REQ-014 ALU codes SHALL be ADD=000, SUB=001, MAIOR=010, MENOR=011, IGUAL=100, XOR=101, AND=110; op=111 latches as ADD.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE when step=STEPS-1, DONE->IDLE unconditionally.
REQ-016 On accepted start at edge k, step SHALL be 0 and busy high from edge k; step increments by 1 per cycle in RUN.
REQ-017 Program in RUN (X,Y,Z): step0 LOAD,RESET,RESET; step1 LOAD,LOAD,HOLD; step2 RESET,LOAD,RESET; step3 RESET,SHIFTR,RESET; step4 RESET,RESET,LOAD.
REQ-018 Steps 5..STEPS-1 SHALL drive HOLD on all channels.
REQ-019 Channels 3..N_REG-1 SHALL drive HOLD at every step.
REQ-020 Tula SHALL equal the latched op in every RUN step and ADD outside RUN.
REQ-021 In IDLE and DONE all channels SHALL drive HOLD and step SHALL be 0.
REQ-022 Commands SHALL be decoded combinationally from the registered state, step and latched op, with no further latency.
REQ-023 done SHALL be high exactly during the DONE cycle; busy SHALL be low there.
REQ-024 start while in RUN or DONE SHALL be ignored and not queued; op changes during RUN SHALL have no effect.
REQ-025 A run SHALL last exactly STEPS cycles; with start held high, IDLE re-accepts it one cycle after DONE.

Reset
REQ-026 rst high SHALL force IDLE, step=0, latched op=ADD, busy=0, done=0 and all channels HOLD, overriding start.
REQ-027 rst asserted mid-RUN SHALL abandon the run without a done pulse.

Configuration
REQ-028 With CONTROLE_SEQ_ABORT_EN defined, input abort (1 bit) SHALL exist; abort high in RUN SHALL drive RESET on all channels for that cycle, then go to IDLE without done.
REQ-029 abort SHALL be ignored in IDLE and DONE; rst has priority over abort.
REQ-030 Without CONTROLE_SEQ_ABORT_EN, the abort port and its logic SHALL be absent, with behaviour otherwise identical.

Structure
REQ-031 Package controle_pkg SHALL hold the command and ALU code constants and the FSM state encoding.
REQ-032 Sub-module controle_rom SHALL map (step, op) to per-channel commands and Tula, purely combinational.

Verification
REQ-033 rst=1 with start=1 -> IDLE, Treg all 000, Tula=000, busy=0, done=0.
REQ-034 start=1 for one cycle with op=001 -> 5 RUN cycles matching REQ-017 with Tula=001, then done=1 for one cycle, then IDLE.
REQ-035 start held high continuously -> runs repeat with one DONE cycle and one IDLE cycle between runs; no overlap.
REQ-036 op=111 -> Tula=000 throughout the run; op toggled mid-run -> Tula unchanged.
REQ-037 rst at step 2 -> next cycle IDLE, no done pulse; with ABORT_EN, abort at step 2 -> Treg all 100 that cycle, then IDLE, no done.
REQ-038 N_REG=5, STEPS=8 -> channels 3-4 always 000, steps 5-7 all HOLD, done after 8 RUN cycles.
